rom_burst_reader: RTL

- Sequences the image ROM's 10-word (20-byte) parallel read port to stream a byte range of the 640x480 8-bit image.
- Walks the range in 20-byte bursts and captures each burst into a local buffer.
- Emits the buffer one 16-bit word per cycle on a valid/ready stream to downstream processing.
- Sits between the image ROM and the processing pipeline, as the ROM's only address master.

---
 rtl/rom_burst_reader_pkg.sv | 37 +++
 rtl/rom_burst_reader_if.sv | 35 +++
 rtl/rom_burst_reader_buf.sv | 54 +++++
 rtl/rom_burst_reader.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/rom_burst_reader_pkg.sv
// Shared definitions for the ROM burst reader.
//   ADDR_W / DATA_W / WORDS / IMG_BYTES : ROM geometry
//   state_t     : reader FSM states
//   word_t      : one 16-bit ROM word
//   burst_words : number of words to emit from one burst, min(WORDS, bytes/2)
package rom_pkg;

  localparam int ADDR_W      = 19;
  localparam int DATA_W      = 16;
  localparam int WORDS       = 10;
  localparam int IMG_BYTES   = 307200;
  localparam int BURST_BYTES = 2 * WORDS;
  localparam int IDX_W       = $clog2(WORDS);
  localparam int CNT_W       = $clog2(WORDS + 1);

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  // Words still owed, capped at one burst.
  function automatic logic [CNT_W-1:0] burst_words(input addr_t remaining);
    addr_t half;
    half = remaining >> 1;
    if (half >= addr_t'(WORDS)) begin
      return CNT_W'(WORDS);
    end
    return half[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/rom_burst_reader_if.sv
// ROM port and output stream bundle of the burst reader.
//   rom_addr  : byte address presented to the ROM (reader drives)
//   rom_data  : WORDS packed words, word k at [16k+15:16k] (ROM drives)
//   out_data / out_valid / out_last : output stream (reader drives)
//   out_ready : downstream acceptance (consumer drives)
// modport master = reader side, modport slave = ROM + consumer side.
interface rom_burst_reader_if;
  import rom_pkg::*;

  addr_t                     rom_addr;
  logic [WORDS*DATA_W-1:0]   rom_data;
  word_t                     out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_last;

  modport master (
    output rom_addr,
    input  rom_data,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_last
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_last
  );

endinterface

// File: rtl/rom_burst_reader_buf.sv
// rom_burst_buf: WORDS-entry capture buffer for one ROM burst.
//   load       : capture load_data and load_count, rewind index to 0
//   load_data  : packed ROM words, word k at [16k+15:16k]
//   load_count : number of valid words in this burst (1..WORDS)
//   advance    : current word accepted downstream, step index
//   out_data   : word at the current index
//   last_word  : current index is the final valid word of the burst
module rom_burst_buf
  import rom_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [WORDS*DATA_W-1:0] load_data,
  input  logic [CNT_W-1:0]        load_count,
  input  logic                    advance,
  output word_t                   out_data,
  output logic                    last_word
);

  word_t            buf_reg [WORDS];
  logic [IDX_W-1:0] idx_reg;
  logic [CNT_W-1:0] count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          buf_reg[gi] <= '0;
        end else if (load) begin
          buf_reg[gi] <= load_data[gi*DATA_W +: DATA_W];
        end
      end
    end
  endgenerate

  assign last_word = (CNT_W'(idx_reg) == count_reg - CNT_W'(1));
  assign out_data  = buf_reg[idx_reg];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg   <= '0;
      count_reg <= '0;
    end else if (load) begin
      idx_reg   <= '0;
      count_reg <= load_count;
    end else if (advance && !last_word) begin
      // Index parks on the final word so it never points past the array.
      idx_reg <= idx_reg + IDX_W'(1);
    end
  end

endmodule

// File: rtl/rom_burst_reader.sv
// rom_burst_reader: streams a byte range of the image ROM as 16-bit words.
// Validates the request, then alternates FETCH (present address, capture a
// 20-byte burst) and DRAIN (emit buffered words on a valid/ready stream).
//   clk, rst            : clock, asynchronous active-high reset
//   start               : request, sampled only in IDLE
//   base_addr, byte_len : range, sampled with start
//   busy                : high outside IDLE
//   done, err           : end-of-transfer pulse, err on bad configuration
//   bus (master)        : ROM address/data and output stream
module rom_burst_reader
  import rom_pkg::*;
#(
  parameter int ROM_LAT = 0
)
(
  input  logic  clk,
  input  logic  rst,
  input  logic  start,
  input  addr_t base_addr,
  input  addr_t byte_len,
  output logic  busy,
  output logic  done,
  output logic  err,
  rom_burst_reader_if.master bus
);

  localparam int LAT_W = (ROM_LAT < 1) ? 1 : $clog2(ROM_LAT + 1);
  localparam logic [ADDR_W:0] IMG_END = (ADDR_W+1)'(IMG_BYTES);

  state_t            state_reg, state_next;
  addr_t             base_reg, len_reg;
  addr_t             rom_addr_reg, remaining_reg;
  logic              err_flag_reg;
  logic [LAT_W-1:0]  lat_cnt_reg;

  logic              cfg_bad, cfg_empty, fetch_last, handshake;
  logic              buf_last, buf_load, last_burst;
  logic [ADDR_W:0]   end_addr;

  // End address is computed one bit wider so an oversized range cannot wrap.
  assign end_addr   = {1'b0, base_reg} + {1'b0, len_reg};
  assign cfg_bad    = len_reg[0] | base_reg[0] | (end_addr > IMG_END);
  assign cfg_empty  = (len_reg == '0);
  assign fetch_last = (lat_cnt_reg == LAT_W'(ROM_LAT));
  assign handshake  = bus.out_valid & bus.out_ready;
  assign last_burst = (remaining_reg == addr_t'(2));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_next    = state_reg;
    busy          = 1'b1;
    done          = 1'b0;
    err           = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    buf_load      = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = CHECK;
      end
      CHECK: begin
        state_next = (cfg_bad || cfg_empty) ? DONE : FETCH;
      end
      FETCH: begin
        if (fetch_last) begin
          buf_load   = 1'b1;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        bus.out_valid = 1'b1;
        bus.out_last  = last_burst;
        if (handshake && buf_last) begin
          state_next = last_burst ? DONE : FETCH;
        end
      end
      DONE: begin
        done       = 1'b1;
        err        = err_flag_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, address walk and byte accounting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_reg      <= '0;
      len_reg       <= '0;
      rom_addr_reg  <= '0;
      remaining_reg <= '0;
      err_flag_reg  <= 1'b0;
      lat_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            base_reg <= base_addr;
            len_reg  <= byte_len;
          end
        end
        CHECK: begin
          err_flag_reg  <= cfg_bad;
          remaining_reg <= len_reg;
          lat_cnt_reg   <= '0;
          // Address only moves when a fetch will actually follow.
          if (!cfg_bad && !cfg_empty) rom_addr_reg <= base_reg;
        end
        FETCH: begin
          if (!fetch_last) lat_cnt_reg <= lat_cnt_reg + LAT_W'(1);
        end
        DRAIN: begin
          if (handshake) begin
            remaining_reg <= remaining_reg - addr_t'(2);
            if (buf_last && !last_burst) begin
              rom_addr_reg <= rom_addr_reg + addr_t'(BURST_BYTES);
              lat_cnt_reg  <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rom_addr = rom_addr_reg;

  rom_burst_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .load_data  (bus.rom_data),
    .load_count (burst_words(remaining_reg)),
    .advance    (handshake),
    .out_data   (bus.out_data),
    .last_word  (buf_last)
  );

endmodule
